// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divide/remainder controller.
// Radix-2 restoring divider, one quotient bit per clock. Divide-by-zero and
// signed overflow finish without iterating. stall holds the executor until
// the done cycle.
module div_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic            r_op_rem;   // op[1]: return remainder rather than quotient
   logic            r_neg_q;
   logic            r_neg_r;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_dvsr;
   logic [XLEN-1:0] r_result;

   logic            w_signed;
   logic            w_neg_q;
   logic            w_neg_r;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_special;
   logic            w_accept;
   logic [XLEN-1:0] w_abs_dvd;
   logic [XLEN-1:0] w_abs_dvs;
   logic [XLEN-1:0] w_spec_quo;
   logic [XLEN-1:0] w_spec_rem;
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_trial;
   logic [XLEN-1:0] w_rem_nx;
   logic [XLEN-1:0] w_quo_nx;
   logic [XLEN-1:0] w_fin_res;
   logic            w_last;

   // Two's-complement negate when n is set; restores the sign after the
   // unsigned magnitude divide.
   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   // Operand decode at acceptance: sign flags, magnitudes, special cases.
   always_comb begin
      w_signed   = ~op[0];
      w_neg_q    = w_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      w_neg_r    = w_signed & dividend[XLEN-1];
      w_div_zero = (divisor == '0);
      w_ovf      = w_signed & (dividend == MOST_NEG) & (divisor == '1);
      w_special  = w_div_zero | w_ovf;
      w_abs_dvd  = cond_neg(dividend, w_signed & dividend[XLEN-1]);
      w_abs_dvs  = cond_neg(divisor,  w_signed & divisor[XLEN-1]);
      w_spec_quo = w_div_zero ? '1 : MOST_NEG;
      w_spec_rem = w_div_zero ? dividend : '0;
      w_accept   = (r_state == S_IDLE) & start & ~flush;
   end

   // One restoring step: shift {rem,quo}, trial-subtract one bit wider so the
   // borrow (bit XLEN) says whether the divisor fits.
   always_comb begin
      w_rem_sh  = {r_rem, r_quo[XLEN-1]};
      w_trial   = w_rem_sh - {1'b0, r_dvsr};
      w_rem_nx  = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
      w_quo_nx  = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
      w_last    = (r_cnt == LAST);
      w_fin_res = r_op_rem ? cond_neg(w_rem_nx, r_neg_r)
                           : cond_neg(w_quo_nx, r_neg_q);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and handshake outputs; flush overrides everything.
   always_comb begin
      w_next = r_state;
      stall  = 1'b0;
      done   = 1'b0;
      busy   = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               stall  = 1'b1;
               w_next = w_special ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            stall = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (flush) begin
         w_next = S_IDLE;
         stall  = 1'b0;
         done   = 1'b0;
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, register the
   // result on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvsr   <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op_rem <= op[1];
         r_neg_q  <= w_neg_q;
         r_neg_r  <= w_neg_r;
         r_cnt    <= '0;
         if (w_special) begin
            r_quo    <= w_spec_quo;
            r_rem    <= w_spec_rem;
            r_result <= op[1] ? w_spec_rem : w_spec_quo;
         end else begin
            r_quo  <= w_abs_dvd;
            r_rem  <= '0;
            r_dvsr <= w_abs_dvs;
         end
      end else if ((r_state == S_CALC) && !flush) begin
         r_rem <= w_rem_nx;
         r_quo <= w_quo_nx;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) r_result <= w_fin_res;
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: the driver pushes the expected result
// and done cycle, a monitor pops and compares whenever done is seen.
module tb_div_sequencer;

   localparam int XLEN = 32;
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   last_done_cyc;
   int   prev_done_cyc;

   div_sequencer #(.XLEN(XLEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .flush    (flush),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compare every done pulse against the head of the scoreboard.
   always @(negedge clk) begin
      #2;
      if (done === 1'b1) begin
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", result, e.res);
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Drive a request in the current cycle (cycle 0 of the op).
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] exp, input int lat);
      exp_t e;
      @(negedge clk);
      start    = 1'b1;
      op       = o;
      dividend = a;
      divisor  = b;
      if (push) begin
         e.res = exp;
         e.cyc = cyc + lat;
         q.push_back(e);
      end
      #1;
      chk("stall_accept", stall, 1'b1);
   endtask

   // Hold start until done, checking stall each cycle; bounded wait.
   task automatic wait_done(input string nm);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) begin
            chk({nm, "_stall_done"}, stall, 1'b0);
            seen  = 1'b1;
            start = 1'b0;
         end else begin
            chk({nm, "_stall_busy"}, stall, 1'b1);
         end
      end
      if (!seen) begin
         chk({nm, "_timeout"}, 32'd0, 32'd1);
         start = 1'b0;
         q.delete();
      end
   endtask

   task automatic run(input string nm, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
      issue(o, a, b, 1'b1, exp, lat);
      wait_done(nm);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      last_done_cyc = 0;
      prev_done_cyc = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      op       = 2'b00;
      dividend = '0;
      divisor  = '0;
      flush    = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy",   busy,   1'b0);
      chk("rst_done",   done,   1'b0);
      chk("rst_stall",  stall,  1'b0);
      chk("rst_result", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Normal signed/unsigned cases.
      run("div_20_m3",  OP_DIV,  32'h14,       32'hFFFFFFFD, 32'hFFFFFFFA, 33);
      run("rem_20_m3",  OP_REM,  32'h14,       32'hFFFFFFFD, 32'h00000002, 33);
      run("rem_m20_3",  OP_REM,  32'hFFFFFFEC, 32'h3,        32'hFFFFFFFE, 33);
      run("divu_max",   OP_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33);
      run("remu_max",   OP_REMU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 33);

      // Divide by zero: finishes in cycle 1.
      run("divu_z",     OP_DIVU, 32'h1234,     32'h0,        32'hFFFFFFFF, 1);
      run("div_z",      OP_DIV,  32'h1234,     32'h0,        32'hFFFFFFFF, 1);
      run("rem_z",      OP_REM,  32'h1234,     32'h0,        32'h00001234, 1);
      run("remu_z",     OP_REMU, 32'h1234,     32'h0,        32'h00001234, 1);

      // Signed overflow.
      run("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run("rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      run("divu_ovf",   OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
      run("remu_z2",    OP_REMU, 32'h1234,     32'h0,        32'h00001234, 1);

      // Flush in CALC cycle 10: no done, result keeps 0x1234.
      issue(OP_DIV, 32'd100, 32'd7, 1'b0, 32'h0, 0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      start = 1'b0;
      #1;
      chk("flush_stall", stall, 1'b0);
      chk("flush_done",  done,  1'b0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_busy",   busy,   1'b0);
      chk("flush_stall2", stall,  1'b0);
      chk("flush_result", result, 32'h00001234);
      repeat (5) @(negedge clk);
      run("after_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

      // Reset mid-CALC.
      issue(OP_DIV, 32'hFFFFFFEC, 32'd3, 1'b0, 32'h0, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_busy",   busy,   1'b0);
      chk("midrst_done",   done,   1'b0);
      chk("midrst_result", result, 32'h0);
      repeat (3) @(negedge clk);

      // Back-to-back.
      run("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run("b2b_remu", OP_REMU, 32'd100, 32'd7, 32'd2,  33);
      @(negedge clk);
      #3;
      chk("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd34);
      chk("sb_empty", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
